vx_commit_arbiter: RTL and testbench

- Consumer end of the commit handshake driven by the execution units (ALU, LSU, SFU, FPU, tensor) for one issue slot.
- Arbitrates the units' commit streams round-robin into a single registered writeback stream toward the register file and scoreboard release.
- Maintains the retired-instruction counter reported to the CSR unit.

---
 rtl/vx_commit_arbiter.sv | 129 ++++++++++++
 tb/tb_vx_commit_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_commit_arbiter.sv
// rtl/vx_commit_arbiter.sv - round-robin commit arbiter with a registered writeback stage and retired-instruction counter
// Optional COMMIT_PERF_EN adds per-unit eop commit counters and a writeback stall-cycle counter.
module vx_commit_arbiter #(
  parameter int NUM_UNITS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int XLEN        = 32,
  localparam int UNIT_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_UNITS-1:0]              in_valid,
  output logic [NUM_UNITS-1:0]              in_ready,
  input  logic [NUM_UNITS*NW_BITS-1:0]      in_wid,
  input  logic [NUM_UNITS*NUM_THREADS-1:0]  in_tmask,
  input  logic [NUM_UNITS*XLEN-1:0]         in_pc,
  input  logic [NUM_UNITS-1:0]              in_wb,
  input  logic [NUM_UNITS*5-1:0]            in_rd,
  input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data,
  input  logic [NUM_UNITS-1:0]              in_eop,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [NW_BITS-1:0]                wb_wid,
  output logic [NUM_THREADS-1:0]            wb_tmask,
  output logic [XLEN-1:0]                   wb_pc,
  output logic                              wb_wb,
  output logic [4:0]                        wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]       wb_data,
  output logic                              wb_eop,
  output logic [UNIT_W-1:0]                 wb_unit,
  output logic [63:0]                       instret
`ifdef COMMIT_PERF_EN
  ,
  output logic [NUM_UNITS*32-1:0]           perf_unit_commits,
  output logic [31:0]                       perf_stall_cycles
`endif
);

  localparam int DW = NUM_THREADS * XLEN;

  logic [UNIT_W-1:0] ptr;
  logic [UNIT_W-1:0] winner;
  logic [UNIT_W-1:0] ptr_next;
  logic              grant_found;
  logic              stage_free;
  logic              load;
  logic              wb_fire;
  int                idx;

  // Scan from ptr upward with wrap; the first valid unit wins.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    idx         = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = (int'(ptr) + k) % NUM_UNITS;
      if (!grant_found && in_valid[idx]) begin
        grant_found = 1'b1;
        winner      = UNIT_W'(idx);
      end
    end
  end

  assign ptr_next   = (winner == UNIT_W'(NUM_UNITS - 1)) ? '0 : winner + UNIT_W'(1);
  assign stage_free = !wb_valid || wb_ready;
  assign load       = stage_free && grant_found && !reset;
  assign wb_fire    = wb_valid && wb_ready && !reset;
  assign in_ready   = load ? (NUM_UNITS'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_wid   <= '0;
      wb_tmask <= '0;
      wb_pc    <= '0;
      wb_wb    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_eop   <= 1'b0;
      wb_unit  <= '0;
      ptr      <= '0;
      instret  <= '0;
    end else begin
      if (stage_free) begin
        wb_valid <= grant_found;
        if (grant_found) begin
          wb_wid   <= in_wid[winner*NW_BITS +: NW_BITS];
          wb_tmask <= in_tmask[winner*NUM_THREADS +: NUM_THREADS];
          wb_pc    <= in_pc[winner*XLEN +: XLEN];
          wb_wb    <= in_wb[winner];
          wb_rd    <= in_rd[winner*5 +: 5];
          wb_data  <= in_data[winner*DW +: DW];
          wb_eop   <= in_eop[winner];
          wb_unit  <= winner;
          ptr      <= ptr_next;
        end
      end
      // Only the last packet of an instruction retires it; tmask is irrelevant.
      if (wb_fire && wb_eop) begin
        instret <= instret + 64'd1;
      end
    end
  end

`ifdef COMMIT_PERF_EN
  logic [31:0] perf_cnt [NUM_UNITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        perf_cnt[i] <= '0;
      end
      perf_stall_cycles <= '0;
    end else begin
      if (wb_fire && wb_eop) begin
        perf_cnt[wb_unit] <= perf_cnt[wb_unit] + 32'd1;
      end
      if (wb_valid && !wb_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_perf
    assign perf_unit_commits[g*32 +: 32] = perf_cnt[g];
  end
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// tb/tb_vx_commit_arbiter.sv - directed self-checking bench for vx_commit_arbiter
module tb_vx_commit_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [7:0]   in_wid;
  logic [15:0]  in_tmask;
  logic [127:0] in_pc;
  logic [3:0]   in_wb;
  logic [19:0]  in_rd;
  logic [511:0] in_data;
  logic [3:0]   in_eop;
  logic         wb_valid;
  logic         wb_ready;
  logic [1:0]   wb_wid;
  logic [3:0]   wb_tmask;
  logic [31:0]  wb_pc;
  logic         wb_wb;
  logic [4:0]   wb_rd;
  logic [127:0] wb_data;
  logic         wb_eop;
  logic [1:0]   wb_unit;
  logic [63:0]  instret;
`ifdef COMMIT_PERF_EN
  logic [127:0] perf_unit_commits;
  logic [31:0]  perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  vx_commit_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_wid   (in_wid),
    .in_tmask (in_tmask),
    .in_pc    (in_pc),
    .in_wb    (in_wb),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .in_eop   (in_eop),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_wid   (wb_wid),
    .wb_tmask (wb_tmask),
    .wb_pc    (wb_pc),
    .wb_wb    (wb_wb),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_eop   (wb_eop),
    .wb_unit  (wb_unit),
    .instret  (instret)
`ifdef COMMIT_PERF_EN
    ,
    .perf_unit_commits (perf_unit_commits),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ok, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [1:0] wid, input logic [3:0] tmask,
                          input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] lane, input logic eop);
    in_wid[u*2 +: 2]      = wid;
    in_tmask[u*4 +: 4]    = tmask;
    in_pc[u*32 +: 32]     = pc;
    in_wb[u]              = 1'b1;
    in_rd[u*5 +: 5]       = rd;
    in_data[u*128 +: 128] = {4{lane}};
    in_eop[u]             = eop;
  endtask

  initial begin
    reset    = 1'b1;
    wb_ready = 1'b1;
    in_valid = 4'hF;
    in_wid   = '0;
    in_tmask = '0;
    in_pc    = '0;
    in_wb    = '0;
    in_rd    = '0;
    in_data  = '0;
    in_eop   = '0;
    tick();
    tick();
    chk("rst_in_ready", in_ready === 4'h0, in_ready, 4'h0);
    chk("rst_wb_valid", wb_valid === 1'b0, wb_valid, 1'b0);
    chk("rst_instret", instret === 64'd0, instret, 64'd0);
    chk("rst_wb_rd", wb_rd === 5'd0, wb_rd, 5'd0);
    chk("rst_wb_data", wb_data === 128'd0, wb_data, 128'd0);
    in_valid = 4'h0;
    reset    = 1'b0;

    set_unit(2, 2'd1, 4'hF, 32'h40, 5'd5, 32'hA, 1'b1);
    in_valid = 4'b0100;
    #1;
    chk("single_in_ready", in_ready === 4'b0100, in_ready, 4'b0100);
    tick();
    in_valid = 4'h0;
    chk("single_wb_valid", wb_valid === 1'b1, wb_valid, 1'b1);
    chk("single_wb_unit", wb_unit === 2'd2, wb_unit, 2'd2);
    chk("single_wb_rd", wb_rd === 5'd5, wb_rd, 5'd5);
    chk("single_wb_wid", wb_wid === 2'd1, wb_wid, 2'd1);
    chk("single_wb_data", wb_data === {4{32'hA}}, wb_data, {4{32'hA}});
    chk("single_instret0", instret === 64'd0, instret, 64'd0);
    tick();
    chk("single_instret1", instret === 64'd1, instret, 64'd1);
    chk("single_wb_idle", wb_valid === 1'b0, wb_valid, 1'b0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_unit(i, 2'(i), 4'hF, 32'(i * 4), 5'(10 + i), 32'(i), 1'b1);
    in_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fair_in_ready", in_ready === 4'(1 << (c % 4)), in_ready, 4'(1 << (c % 4)));
      tick();
      chk("fair_wb_unit", wb_unit === 2'(c % 4), wb_unit, 2'(c % 4));
      chk("fair_wb_rd", wb_rd === 5'(10 + c % 4), wb_rd, 5'(10 + c % 4));
    end
    in_valid = 4'h0;
    chk("fair_instret5", instret === 64'd5, instret, 64'd5);
    tick();
    chk("fair_instret6", instret === 64'd6, instret, 64'd6);
    chk("fair_wb_idle", wb_valid === 1'b0, wb_valid, 1'b0);

    set_unit(0, 2'd3, 4'hF, 32'h100, 5'd7, 32'h77, 1'b1);
    in_valid = 4'b0001;
    #1;
    chk("bp_in_ready", in_ready === 4'b0001, in_ready, 4'b0001);
    tick();
    wb_ready = 1'b0;
    in_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_stall_ready", in_ready === 4'h0, in_ready, 4'h0);
      tick();
      chk("bp_wb_valid", wb_valid === 1'b1, wb_valid, 1'b1);
      chk("bp_wb_rd", wb_rd === 5'd7, wb_rd, 5'd7);
      chk("bp_wb_pc", wb_pc === 32'h100, wb_pc, 32'h100);
      chk("bp_wb_unit", wb_unit === 2'd0, wb_unit, 2'd0);
      chk("bp_instret", instret === 64'd6, instret, 64'd6);
    end
    in_valid = 4'h0;
    wb_ready = 1'b1;
    tick();
    chk("bp_drain_instret", instret === 64'd7, instret, 64'd7);
    chk("bp_drain_idle", wb_valid === 1'b0, wb_valid, 1'b0);

    set_unit(1, 2'd2, 4'hF, 32'h200, 5'd3, 32'h11, 1'b0);
    in_valid = 4'b0010;
    #1;
    chk("neop_rdy0", in_ready === 4'b0010, in_ready, 4'b0010);
    tick();
    chk("neop_eop0", wb_eop === 1'b0, wb_eop, 1'b0);
    chk("neop_data0", wb_data === {4{32'h11}}, wb_data, {4{32'h11}});
    set_unit(1, 2'd2, 4'h0, 32'h200, 5'd3, 32'h22, 1'b1);
    #1;
    chk("neop_rdy1", in_ready === 4'b0010, in_ready, 4'b0010);
    tick();
    in_valid = 4'h0;
    chk("neop_eop1", wb_eop === 1'b1, wb_eop, 1'b1);
    chk("neop_data1", wb_data === {4{32'h22}}, wb_data, {4{32'h22}});
    chk("neop_tmask1", wb_tmask === 4'h0, wb_tmask, 4'h0);
    chk("neop_instret_mid", instret === 64'd7, instret, 64'd7);
    tick();
    chk("neop_instret", instret === 64'd8, instret, 64'd8);

    set_unit(2, 2'd0, 4'hF, 32'h300, 5'd9, 32'h9, 1'b1);
    in_valid = 4'b0100;
    tick();
    set_unit(3, 2'd0, 4'hF, 32'h304, 5'd13, 32'hD, 1'b1);
    set_unit(0, 2'd0, 4'hF, 32'h308, 5'd10, 32'hE, 1'b1);
    in_valid = 4'b1001;
    #1;
    chk("wrap_rdy3", in_ready === 4'b1000, in_ready, 4'b1000);
    tick();
    chk("wrap_unit3", wb_unit === 2'd3, wb_unit, 2'd3);
    in_valid = 4'b0001;
    #1;
    chk("wrap_rdy0", in_ready === 4'b0001, in_ready, 4'b0001);
    tick();
    chk("wrap_unit0", wb_unit === 2'd0, wb_unit, 2'd0);
    in_valid = 4'h0;
    tick();
    chk("wrap_instret", instret === 64'd11, instret, 64'd11);

    set_unit(1, 2'd1, 4'hF, 32'h400, 5'd4, 32'h4, 1'b1);
    in_valid = 4'b0010;
    tick();
    in_valid = 4'h0;
    wb_ready = 1'b0;
    tick();
    chk("rs_wb_valid", wb_valid === 1'b1, wb_valid, 1'b1);
    chk("rs_wb_unit", wb_unit === 2'd1, wb_unit, 2'd1);
`ifdef COMMIT_PERF_EN
    chk("rs_perf_stall_pre", perf_stall_cycles === 32'd4, perf_stall_cycles, 32'd4);
    chk("rs_perf_u0_pre", perf_unit_commits[31:0] === 32'd4, perf_unit_commits[31:0], 32'd4);
`endif
    reset    = 1'b1;
    wb_ready = 1'b1;
    tick();
    chk("rs_wb_valid0", wb_valid === 1'b0, wb_valid, 1'b0);
    chk("rs_instret0", instret === 64'd0, instret, 64'd0);
    chk("rs_wb_rd0", wb_rd === 5'd0, wb_rd, 5'd0);
    chk("rs_wb_unit0", wb_unit === 2'd0, wb_unit, 2'd0);
`ifdef COMMIT_PERF_EN
    chk("rs_perf_units0", perf_unit_commits === 128'd0, perf_unit_commits, 128'd0);
    chk("rs_perf_stall0", perf_stall_cycles === 32'd0, perf_stall_cycles, 32'd0);
`endif
    reset    = 1'b0;
    in_valid = 4'hF;
    #1;
    chk("rs_ptr0", in_ready === 4'b0001, in_ready, 4'b0001);
    in_valid = 4'h0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
